// File: rtl/uart_pkg.sv
// Shared UART-side constants and the tx queue sequencer state encoding.
// Clock/baud defaults are consumed by the transmitter/receiver blocks.
package uart_pkg;

  localparam int UART_BYTE_W       = 8;
  localparam int UART_CLK_HZ       = 50_000_000;
  localparam int UART_BAUD         = 115_200;
  localparam int UART_CLKS_PER_BIT = UART_CLK_HZ / UART_BAUD;

  typedef enum logic [1:0] {
    IDLE      = 2'd0,
    WAIT_DONE = 2'd1,
    GAP       = 2'd2
  } txq_state_e;

endpackage

// File: rtl/sync_fifo.sv
// Circular-buffer FIFO, registered full/empty/count; head data is a direct read of the storage.
// Pushes while full and pops while empty are ignored; a simultaneous push and pop keeps count.
module sync_fifo #(
  parameter int WIDTH = 8,
  parameter int DEPTH = 16
) (
  input  logic                   clk_i,
  input  logic                   rst_i,
  input  logic                   wr_vld_i,
  input  logic [WIDTH-1:0]       wr_dat_i,
  input  logic                   rd_rdy_i,
  output logic [WIDTH-1:0]       rd_dat_o,
  output logic                   full_o,
  output logic                   empty_o,
  output logic [$clog2(DEPTH):0] count_o
);

  localparam int AW = $clog2(DEPTH);
  localparam logic [AW:0] CNT_FULL = (AW+1)'(DEPTH);

  logic [AW:0]      wr_ptr_q, wr_ptr_d;
  logic [AW:0]      rd_ptr_q, rd_ptr_d;
  logic [AW:0]      count_q, count_d;
  logic             full_q, empty_q;
  logic             push, pop;
  logic [WIDTH-1:0] mem_q [DEPTH];

  // Acceptance uses the flags registered at the start of the cycle.
  assign push = wr_vld_i & ~full_q;
  assign pop  = rd_rdy_i & ~empty_q;

  always_comb begin
    wr_ptr_d = wr_ptr_q + {{AW{1'b0}}, push};
    rd_ptr_d = rd_ptr_q + {{AW{1'b0}}, pop};
    count_d  = wr_ptr_d - rd_ptr_d;
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
      full_q   <= 1'b0;
      empty_q  <= 1'b1;
    end else begin
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      count_q  <= count_d;
      full_q   <= (count_d == CNT_FULL);
      empty_q  <= (count_d == '0);
    end
  end

  always_ff @(posedge clk_i) begin
    if (push) begin
      mem_q[wr_ptr_q[AW-1:0]] <= wr_dat_i;
    end
  end

  assign rd_dat_o = mem_q[rd_ptr_q[AW-1:0]];
  assign full_o   = full_q;
  assign empty_o  = empty_q;
  assign count_o  = count_q;

endmodule

// File: rtl/uart_tx_queue.sv
// Byte queue feeding the UART transmitter: pops one byte per frame, waits for TXDONE plus an optional gap.
// Push-to-TXSTART is 2 cycles when idle; pushes while FULL are dropped and latch OVERFLOW.
module uart_tx_queue
  import uart_pkg::*;
#(
  parameter int DEPTH      = 16,
  parameter int GAP_CYCLES = 0
) (
  input  logic                   CLK,
  input  logic                   RESET,
  input  logic                   WR_EN,
  input  logic [UART_BYTE_W-1:0] WR_DATA,
  output logic                   FULL,
  output logic                   EMPTY,
  output logic [$clog2(DEPTH):0] COUNT,
  output logic                   OVERFLOW,
  output logic [UART_BYTE_W-1:0] TXDATA,
  output logic                   TXSTART,
  input  logic                   TXBUSY,
  input  logic                   TXDONE
);

  localparam int GAP_W = (GAP_CYCLES > 1) ? $clog2(GAP_CYCLES) : 1;
  localparam logic [GAP_W-1:0] GAP_LOAD = (GAP_CYCLES > 0) ? GAP_W'(GAP_CYCLES - 1) : '0;

  txq_state_e             state_q, state_d;
  logic [UART_BYTE_W-1:0] txdata_q, txdata_d;
  logic                   txstart_q, txstart_d;
  logic [GAP_W-1:0]       gap_cnt_q, gap_cnt_d;
  logic                   overflow_q, overflow_d;
  logic                   pop;
  logic [UART_BYTE_W-1:0] head_dat;
  logic                   fifo_full, fifo_empty;

  sync_fifo #(
    .WIDTH (UART_BYTE_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk_i    (CLK),
    .rst_i    (RESET),
    .wr_vld_i (WR_EN),
    .wr_dat_i (WR_DATA),
    .rd_rdy_i (pop),
    .rd_dat_o (head_dat),
    .full_o   (fifo_full),
    .empty_o  (fifo_empty),
    .count_o  (COUNT)
  );

  always_comb begin
    state_d    = state_q;
    txdata_d   = txdata_q;
    txstart_d  = 1'b0;
    gap_cnt_d  = gap_cnt_q;
    pop        = 1'b0;
    overflow_d = overflow_q | (WR_EN & fifo_full);
    case (state_q)
      IDLE: begin
        if (!fifo_empty && !TXBUSY) begin
          pop       = 1'b1;
          txdata_d  = head_dat;
          txstart_d = 1'b1;
          state_d   = WAIT_DONE;
        end
      end
      WAIT_DONE: begin
        if (TXDONE) begin
          if (GAP_CYCLES > 0) begin
            state_d   = GAP;
            gap_cnt_d = GAP_LOAD;
          end else begin
            state_d = IDLE;
          end
        end
      end
      GAP: begin
        // TXDONE is deliberately not looked at here.
        if (gap_cnt_q == '0) begin
          state_d = IDLE;
        end else begin
          gap_cnt_d = gap_cnt_q - GAP_W'(1);
        end
      end
      default: state_d = IDLE;
    endcase
  end

  always_ff @(posedge CLK) begin
    if (RESET) begin
      state_q    <= IDLE;
      txdata_q   <= '0;
      txstart_q  <= 1'b0;
      gap_cnt_q  <= '0;
      overflow_q <= 1'b0;
    end else begin
      state_q    <= state_d;
      txdata_q   <= txdata_d;
      txstart_q  <= txstart_d;
      gap_cnt_q  <= gap_cnt_d;
      overflow_q <= overflow_d;
    end
  end

  assign FULL     = fifo_full;
  assign EMPTY    = fifo_empty;
  assign OVERFLOW = overflow_q;
  assign TXDATA   = txdata_q;
  assign TXSTART  = txstart_q;

endmodule
